// File: rtl/inference_sequencer.sv
// Job sequencer for an 8-row int8 systolic array: streams weights, then inputs,
// and buffers array results in a small FIFO with backpressure toward the row stream.
module inference_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_num_input,
  input  logic [1:0]  cmd_act_mode,
  input  logic [63:0] cmd_bias,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        start_weights,
  output logic        start_array,
  output logic        enable,
  output logic [63:0] systolic_data,
  output logic [63:0] bias_vec,
  output logic [6:0]  num_input,
  output logic [1:0]  activation_mode,
  input  logic        activated,
  input  logic [63:0] activations,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy,
  output logic        done,
  output logic        ovf_err
);

  typedef enum logic [2:0] {IDLE, LOAD_W, GAP, FEED, DRAIN, DONE} state_t;

  state_t      state, state_nx;
  logic [2:0]  w_cnt;
  logic [6:0]  in_cnt, res_cnt;
  logic [63:0] fifo_mem [4];
  logic [1:0]  rd_ptr, wr_ptr;
  logic [2:0]  fifo_cnt;
  logic        accept, xfer, fifo_hold, push, pop, full, push_ok;

  always_comb begin
    cmd_ready     = (state == IDLE);
    accept        = cmd_valid & cmd_ready;
    // Hold off new rows once three results are waiting so in-flight ones still fit.
    fifo_hold     = (fifo_cnt >= 3'd3);
    in_ready      = ((state == LOAD_W) || (state == FEED)) && !fifo_hold;
    xfer          = in_valid & in_ready;
    systolic_data = xfer ? in_data : 64'h0;
    push          = activated & (state != IDLE);
    out_valid     = (fifo_cnt != 3'd0);
    out_data      = out_valid ? fifo_mem[rd_ptr] : 64'h0;
    pop           = out_valid & out_ready;
    full          = (fifo_cnt == 3'd4);
    push_ok       = push & (~full | pop);
    busy          = (state != IDLE);
  end

  always_comb begin
    state_nx      = state;
    enable        = 1'b0;
    start_weights = 1'b0;
    start_array   = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE:   if (accept) state_nx = LOAD_W;
      LOAD_W: begin
        enable        = xfer;
        start_weights = xfer && (w_cnt == 3'd0);
        if (xfer && (w_cnt == 3'd7)) state_nx = GAP;
      end
      GAP:    state_nx = (num_input != 7'd0) ? FEED : DONE;
      FEED: begin
        enable      = xfer;
        start_array = xfer && (in_cnt == 7'd0);
        if (xfer && (in_cnt == num_input - 7'd1)) state_nx = DRAIN;
      end
      DRAIN: begin
        // Keep the array clocking to flush results unless the FIFO is backing up.
        enable = ~fifo_hold;
        if ((res_cnt == num_input) && (fifo_cnt == 3'd0)) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      w_cnt           <= 3'd0;
      in_cnt          <= 7'd0;
      res_cnt         <= 7'd0;
      bias_vec        <= 64'h0;
      num_input       <= 7'd0;
      activation_mode <= 2'd0;
      rd_ptr          <= 2'd0;
      wr_ptr          <= 2'd0;
      fifo_cnt        <= 3'd0;
      ovf_err         <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        bias_vec        <= cmd_bias;
        num_input       <= cmd_num_input;
        activation_mode <= cmd_act_mode;
        w_cnt           <= 3'd0;
        in_cnt          <= 7'd0;
        res_cnt         <= 7'd0;
      end else begin
        if ((state == LOAD_W) && xfer) w_cnt  <= w_cnt + 3'd1;
        if ((state == FEED) && xfer)   in_cnt <= in_cnt + 7'd1;
        if (push)                      res_cnt <= res_cnt + 7'd1;
      end
      if (push_ok)        wr_ptr  <= wr_ptr + 2'd1;
      if (pop)            rd_ptr  <= rd_ptr + 2'd1;
      if (push & ~push_ok) ovf_err <= 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Storage needs no reset: out_data is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= activations;
  end

endmodule

// File: tb/tb_inference_sequencer.sv
// Bench for inference_sequencer: directed cycle table, corner sequences, and
// randomized jobs checked against a queue-based reference model.
module tb_inference_sequencer;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [6:0]  cmd_num_input = '0;
  logic [1:0]  cmd_act_mode = '0;
  logic [63:0] cmd_bias = '0;
  logic        in_valid = 1'b0, in_ready;
  logic [63:0] in_data = '0;
  logic        start_weights, start_array, enable;
  logic [63:0] systolic_data, bias_vec;
  logic [6:0]  num_input;
  logic [1:0]  activation_mode;
  logic        activated = 1'b0;
  logic [63:0] activations = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [63:0] out_data;
  logic        busy, done, ovf_err;

  always #5 clk = ~clk;

  inference_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_num_input(cmd_num_input), .cmd_act_mode(cmd_act_mode), .cmd_bias(cmd_bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .start_weights(start_weights), .start_array(start_array), .enable(enable),
    .systolic_data(systolic_data), .bias_vec(bias_vec), .num_input(num_input),
    .activation_mode(activation_mode), .activated(activated), .activations(activations),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .ovf_err(ovf_err));

  localparam logic [63:0] W   = 64'h0202020202020202;
  localparam logic [63:0] IN0 = 64'h0102030405060708;
  localparam logic [63:0] IN1 = 64'h050a050a050a050a;
  localparam logic [63:0] IN2 = 64'h0408040804080408;

  typedef struct {
    logic        iv;
    logic [63:0] d;
    logic        rdy, en, sw, sa;
    logic [63:0] sys;
  } vec_t;

  typedef struct {
    int          t;
    logic [63:0] v;
  } pend_t;

  int checks = 0, failures = 0;
  logic [63:0] got[$];
  int done_cnt = 0, sw_cnt = 0, sa_cnt = 0;

  // Observed result stream and pulse counts.
  always @(negedge clk) begin
    if (out_valid && out_ready) got.push_back(out_data);
    if (done) done_cnt++;
    if (start_weights) sw_cnt++;
    if (start_array) sa_cnt++;
  end

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic fail_to(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] array_fn(input logic [63:0] r, input logic [63:0] b);
    return r + b;
  endfunction

  task automatic issue_cmd(input logic [6:0] n, input logic [1:0] m, input logic [63:0] b);
    cmd_valid = 1'b1; cmd_num_input = n; cmd_act_mode = m; cmd_bias = b;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    next_cyc();
    cmd_valid = 1'b0; cmd_num_input = '0; cmd_act_mode = '0; cmd_bias = '0;
    chk("cfg_num_input", num_input, n);
    chk("cfg_mode", activation_mode, m);
    chk("cfg_bias", bias_vec, b);
    got.delete(); done_cnt = 0; sw_cnt = 0; sa_cnt = 0;
  endtask

  task automatic send_row(input logic [63:0] d);
    int n = 0;
    in_valid = 1'b1; in_data = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) fail_to("send_row");
    next_cyc();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done_cnt == 0 && n < limit) begin next_cyc(); n++; end
    if (done_cnt == 0) fail_to("wait_done");
    next_cyc(); next_cyc();
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_enable"}, enable, 0);
    chk({tag, "_sysdata"}, systolic_data, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovf"}, ovf_err, 0);
    chk({tag, "_num_input"}, num_input, 0);
    chk({tag, "_bias"}, bias_vec, 0);
    chk({tag, "_mode"}, activation_mode, 0);
    chk({tag, "_starts"}, {start_weights, start_array}, 0);
  endtask

  // Random job: random row/ready gaps and array latency, results checked in order.
  task automatic run_job(input logic [6:0] n, input logic [1:0] m, input logic [63:0] b);
    logic [63:0] rows[$];
    logic [63:0] expq[$];
    pend_t pend[$];
    int sent = 0, pushes = 0, cyc = 0, cnt;
    bit drv_act;
    for (int i = 0; i < 8 + n; i++) rows.push_back({$urandom, $urandom});
    for (int i = 8; i < 8 + n; i++) expq.push_back(array_fn(rows[i], b));
    issue_cmd(n, m, b);
    while (cyc < 600 && done_cnt == 0) begin
      cnt = pushes - got.size();
      in_valid  = (sent < 8 + n) && ($urandom_range(0, 3) != 0);
      in_data   = (sent < 8 + n) ? rows[sent] : 64'h0;
      out_ready = ($urandom_range(0, 2) != 0);
      drv_act   = (pend.size() > 0) && (pend[0].t <= cyc) && (cnt < 3);
      activated   = drv_act;
      activations = drv_act ? pend[0].v : 64'h0;
      if (drv_act) begin void'(pend.pop_front()); pushes++; end
      @(negedge clk);
      if (cnt >= 3) begin
        chk("rj_hold_in_ready", in_ready, 0);
        chk("rj_hold_enable", enable, 0);
      end
      if (in_valid && in_ready) begin
        chk("rj_sysdata", systolic_data, in_data);
        chk("rj_enable", enable, 1);
        chk("rj_start_w", start_weights, (sent == 0));
        chk("rj_start_a", start_array, (sent == 8));
        if (sent >= 8) pend.push_back('{cyc + $urandom_range(1, 4), array_fn(rows[sent], b)});
        sent++;
      end else begin
        chk("rj_sysdata_idle", systolic_data, 0);
        chk("rj_starts_idle", {start_weights, start_array}, 0);
      end
      chk("rj_cfg", {bias_vec, num_input, activation_mode}, {b, n, m});
      next_cyc();
      cyc++;
    end
    in_valid = 1'b0; activated = 1'b0; out_ready = 1'b1;
    if (done_cnt == 0) fail_to("run_job_done");
    next_cyc(); next_cyc();
    chk("rj_done_once", done_cnt, 1);
    chk("rj_result_count", got.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got.size(); i++)
      chk($sformatf("rj_result%0d", i), got[i], expq[i]);
    chk("rj_sw_cnt", sw_cnt, 1);
    chk("rj_sa_cnt", sa_cnt, (n != 0));
    chk("rj_busy_end", busy, 0);
    chk("rj_cmd_ready_end", cmd_ready, 1);
    chk("rj_ovf", ovf_err, 0);
  endtask

  initial begin
    vec_t vt[14];
    logic [63:0] r[3];
    logic [63:0] v[5];

    // Reset state
    #1;
    reset_check("rst0");
    next_cyc(); next_cyc();
    rst = 1'b0;
    @(negedge clk);
    reset_check("rst1");
    next_cyc();

    // Directed job: 8 weights, one-cycle GAP, 3 inputs with a one-cycle in_valid gap
    for (int i = 0; i < 8; i++) vt[i] = '{1'b1, W, 1'b1, 1'b1, (i == 0), 1'b0, W};
    vt[8]  = '{1'b1, IN0,   1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
    vt[9]  = '{1'b1, IN0,   1'b1, 1'b1, 1'b0, 1'b1, IN0};
    vt[10] = '{1'b1, IN1,   1'b1, 1'b1, 1'b0, 1'b0, IN1};
    vt[11] = '{1'b0, IN2,   1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
    vt[12] = '{1'b1, IN2,   1'b1, 1'b1, 1'b0, 1'b0, IN2};
    vt[13] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0};
    out_ready = 1'b1;
    issue_cmd(7'd3, 2'd2, 64'h0);
    for (int i = 0; i < 14; i++) begin
      in_valid = vt[i].iv; in_data = vt[i].d;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vt[i].rdy);
      chk($sformatf("vec%0d_enable", i), enable, vt[i].en);
      chk($sformatf("vec%0d_start_w", i), start_weights, vt[i].sw);
      chk($sformatf("vec%0d_start_a", i), start_array, vt[i].sa);
      chk($sformatf("vec%0d_sysdata", i), systolic_data, vt[i].sys);
      chk($sformatf("vec%0d_busy", i), busy, 1);
      next_cyc();
    end
    in_valid = 1'b0;

    // Three array results drained in order, then exactly one done pulse
    r[0] = 64'h1111_2222_3333_4444; r[1] = 64'h8000_0000_0000_0001; r[2] = 64'hffff_0000_ffff_0000;
    for (int k = 0; k < 3; k++) begin
      activated = 1'b1; activations = r[k];
      next_cyc();
    end
    activated = 1'b0;
    wait_done(30);
    chk("d1_results", got.size(), 3);
    for (int k = 0; k < 3 && k < got.size(); k++) chk($sformatf("d1_result%0d", k), got[k], r[k]);
    chk("d1_done_once", done_cnt, 1);
    chk("d1_busy", busy, 0);
    chk("d1_cmd_ready", cmd_ready, 1);

    // Backpressure: 3 results pending with out_ready=0 stalls the row stream
    issue_cmd(7'd5, 2'd1, 64'h0101_0101_0101_0101);
    for (int i = 0; i < 8; i++) send_row(W);
    send_row(IN0); send_row(IN1);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      activated = 1'b1; activations = r[k];
      next_cyc();
    end
    activated = 1'b0;
    in_valid = 1'b1; in_data = IN2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_enable", enable, 0);
      chk("bp_sysdata", systolic_data, 0);
      chk("bp_ovf", ovf_err, 0);
      chk("bp_head", out_data, r[0]);
      next_cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    send_row(IN2); send_row(IN0); send_row(IN1);
    activated = 1'b1; activations = 64'hAA; next_cyc();
    activations = 64'hBB; next_cyc();
    activated = 1'b0;
    wait_done(40);
    chk("bp_results", got.size(), 5);
    if (got.size() == 5) chk("bp_tail", {got[3][7:0], got[4][7:0]}, 16'hAABB);
    chk("bp_done_once", done_cnt, 1);
    chk("bp_ovf_end", ovf_err, 0);

    // num_input = 0: weights, GAP, DONE with no input phase
    issue_cmd(7'd0, 2'd3, 64'h55);
    for (int i = 0; i < 8; i++) send_row(W);
    @(negedge clk);
    chk("z_gap_enable", enable, 0);
    chk("z_gap_in_ready", in_ready, 0);
    chk("z_gap_done", done, 0);
    next_cyc();
    @(negedge clk);
    chk("z_done", done, 1);
    chk("z_done_busy", busy, 1);
    next_cyc();
    @(negedge clk);
    chk("z_idle_busy", busy, 0);
    chk("z_idle_done", done, 0);
    next_cyc();
    chk("z_sa_cnt", sa_cnt, 0);
    chk("z_sw_cnt", sw_cnt, 1);
    chk("z_done_cnt", done_cnt, 1);

    // Overflow: five pushes into a 4-deep FIFO drop the last and latch ovf_err
    issue_cmd(7'd5, 2'd0, 64'h0);
    for (int i = 0; i < 8; i++) send_row(W);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      v[k] = 64'h100 + 64'(k);
      activated = 1'b1; activations = v[k];
      next_cyc();
    end
    activated = 1'b0;
    @(negedge clk);
    chk("ov_flag", ovf_err, 1);
    chk("ov_head", out_data, v[0]);
    chk("ov_in_ready", in_ready, 0);
    next_cyc();
    out_ready = 1'b1;
    for (int n = 0; n < 20 && got.size() < 4; n++) next_cyc();
    chk("ov_kept", got.size(), 4);
    for (int k = 0; k < 4 && k < got.size(); k++) chk($sformatf("ov_word%0d", k), got[k], v[k]);
    for (int i = 0; i < 5; i++) send_row(IN0);
    wait_done(20);
    chk("ov_done_once", done_cnt, 1);
    chk("ov_sticky", ovf_err, 1);
    rst = 1'b1;
    #1;
    chk("ov_cleared", ovf_err, 0);
    next_cyc();
    rst = 1'b0;

    // Reset during FEED abandons the job immediately
    issue_cmd(7'd4, 2'd1, 64'hDEAD_BEEF_0000_0001);
    for (int i = 0; i < 8; i++) send_row(W);
    send_row(IN0);
    out_ready = 1'b0;
    activated = 1'b1; activations = 64'h77; next_cyc();
    activated = 1'b0;
    in_valid = 1'b1; in_data = IN1;
    @(negedge clk);
    chk("mr_pre_valid", out_valid, 1);
    chk("mr_pre_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    reset_check("mr");
    next_cyc();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    next_cyc(); next_cyc(); next_cyc();
    chk("mr_no_done", done_cnt, 0);
    run_job(7'd3, 2'd2, {$urandom, $urandom});

    // Randomized jobs
    for (int j = 0; j < 12; j++)
      run_job(7'($urandom_range(0, 6)), 2'($urandom_range(0, 3)), {$urandom, $urandom});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inference_sequencer.md
INFERENCE_SEQUENCER -- requirements
Module: inference_sequencer

Interface
REQ-001 SHALL have no parameters; the array is fixed at 8 weight rows of 64 bits (8 x int8).
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 cmd_valid / cmd_ready  in / out  1 / 1  job command handshake.
REQ-005 cmd_num_input  in  7  input rows for the job.
REQ-006 cmd_act_mode  in  2  activation mode for the job.
REQ-007 cmd_bias  in  64  bias vector for the job.
REQ-008 in_valid / in_ready  in / out  1 / 1  row stream handshake: 8 weight rows, then cmd_num_input input rows.
REQ-009 in_data  in  64  row payload.
REQ-010 start_weights, start_array, enable  out  1 each  array control.
REQ-011 systolic_data  out  64  row driven into the array.
REQ-012 bias_vec, num_input, activation_mode  out  64, 7, 2  job configuration to the array.
REQ-013 activated  in  1  array result strobe; activations  in  64  array result.
REQ-014 out_valid / out_ready  out / in  1 / 1  result stream handshake; out_data  out  64.
REQ-015 busy  out  1  job in progress; done  out  1  one-cycle job-complete pulse; ovf_err  out  1  sticky result overflow.

Function
REQ-016 FSM states SHALL be IDLE, LOAD_W, GAP, FEED, DRAIN, DONE.
REQ-017 cmd_ready SHALL equal (state==IDLE); a cmd_valid&cmd_ready cycle SHALL register bias_vec, num_input and activation_mode, which then hold until the next accept, and move to LOAD_W.
REQ-018 Row transfer SHALL occur on in_valid&in_ready; in_ready = (state in {LOAD_W, FEED}) & ~fifo_hold, where fifo_hold = (result FIFO count >= 3).
REQ-019 enable SHALL equal row transfer in LOAD_W/FEED, ~fifo_hold in DRAIN, and 0 in IDLE, GAP, DONE.
REQ-020 systolic_data SHALL equal in_data on a transfer cycle and 64'h0 otherwise.
REQ-021 start_weights SHALL pulse only on the first weight-row transfer; start_array only on the first input-row transfer; stall cycles before them do not assert them.
REQ-022 LOAD_W SHALL count 8 transfers (3-bit counter), then enter GAP for exactly one cycle with enable=0.
REQ-023 GAP SHALL go to FEED if num_input!=0, else to DONE.
REQ-024 FEED SHALL count num_input transfers, then enter DRAIN.
REQ-025 A 4-entry result FIFO SHALL push activations on every cycle activated=1 in any state after accept; out_valid = FIFO non-empty, out_data = head, pop on out_valid&out_ready.
REQ-026 Simultaneous push and pop SHALL leave count unchanged; push while full SHALL drop the word and set ovf_err until reset.
REQ-027 A 7-bit result counter SHALL count activated pulses; DRAIN SHALL exit to DONE when count == num_input and FIFO empty.
REQ-028 DONE SHALL last one cycle with done=1, then return to IDLE; busy = (state != IDLE).
REQ-029 Counters SHALL clear on command accept; activated in IDLE SHALL be ignored.

Reset
REQ-030 On rst=1 all state SHALL clear immediately: state IDLE, counters 0, FIFO empty, ovf_err 0, all outputs 0 except cmd_ready=1.
REQ-031 Reset mid-job SHALL abandon the job and discard FIFO contents; no done pulse is produced.

Verification
REQ-032 Cmd(num_input=3, mode=2, bias=0); 8 rows 64'h0202020202020202 back-to-back -> start_weights at row 1 only, 8 enable cycles, one enable=0 GAP cycle.
REQ-033 Inputs 64'h0102030405060708, 64'h050a050a050a050a, 64'h0408040804080408 with in_valid dropped one cycle after row 2 -> start_array at row 1 only, enable=0 and systolic_data=0 during the gap, 3 input transfers.
REQ-034 Array model returns 3 activated pulses, out_ready=1 -> 3 results in order, then done pulse exactly once, busy falls, cmd_ready=1.
REQ-035 out_ready=0 with 3 results pending -> enable and in_ready drop at FIFO count 3; no ovf_err; release out_ready -> job completes.
REQ-036 Cmd with num_input=0 -> 8 weight rows, GAP, DONE; no start_array, no FEED.
REQ-037 rst pulsed during FEED -> outputs at reset values same cycle; a new command afterwards runs to completion normally.
